commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- Retire-stage consumer of the ROB commit handshake. Accepts one committed entry per cycle.
- Side effects per accepted entry:
  - updates the architectural (committed) RAT;
  - returns the old physical destination to the free list;
  - releases committed stores to the LSU store buffer.
- Counts retired instructions, branches and mispredicts for performance monitoring.

Parameters:
ROB_W_P, ROB_W, ROB index width
PHYS_W_P, PHYS_W, physical register index width
ARCH_W_P, 5, architectural register index width
CNT_W_P, 32, performance counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
commit_valid  input  1  ROB head entry ready to retire
commit_ready  output  1  unit accepts head entry this cycle
commit_entry  input  rob_entry_t  committed entry (uses_rd, rd_arch, pd_new, pd_old, is_branch, mispredict, is_store, pc)
commit_rob_idx  input  ROB_W_P  ROB index of head entry
flush_valid  input  1  pipeline nuke
arat_we  output  1  architectural RAT write strobe
arat_rd  output  ARCH_W_P  architectural register written
arat_pd  output  PHYS_W_P  new committed mapping (pd_new)
free_valid  output  1  pd_old return request to free list
free_ready  input  1  free list accepts
free_pd  output  PHYS_W_P  physical register being freed
st_commit_valid  output  1  store release request to store buffer
st_commit_ready  input  1  store buffer accepts
st_commit_rob_idx  output  ROB_W_P  ROB index of released store
retired_cnt  output  CNT_W_P  instructions retired
branch_cnt  output  CNT_W_P  branches retired
mispredict_cnt  output  CNT_W_P  mispredicted branches retired

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - rst is synchronous and active-high.
  - On reset, every output register is 0: arat_we, free_valid, st_commit_valid, pending flags and all counters.
  - Reset mid-handshake drops pending requests without completing them.
- Accept condition:
  - commit_fire = commit_valid && commit_ready.
  - commit_ready = !flush_valid && (!pend_free || free_fire) && (!pend_store || st_fire).
  - free_fire = free_valid && free_ready; st_fire = st_commit_valid && st_commit_ready.
  - Back-to-back acceptance therefore runs at 1 entry/cycle when downstream is not backpressuring.
- On commit_fire, register update at the next edge:
  - pend_free <= uses_rd && rd_arch != 0; free_pd <= pd_old.
  - pend_store <= is_store; st_commit_rob_idx <= commit_rob_idx.
  - arat_we <= uses_rd && rd_arch != 0; arat_rd <= rd_arch; arat_pd <= pd_new.
    - arat_we is a single-cycle pulse with latency 1 and no backpressure.
  - retired_cnt += 1.
  - branch_cnt += is_branch.
  - mispredict_cnt += is_branch && mispredict.
- Handshake outputs:
  - free_valid = pend_free; st_commit_valid = pend_store.
  - Each request holds its payload stable until its own fire.
  - The two requests complete independently; a fire clears its pending flag unless a new commit_fire in the same cycle reloads it.
- Simultaneous reload: a fire and a commit_fire in the same cycle load the new entry's flags and payload. No bubble, no lost request.
- Idle cycle: when there is no commit_fire, arat_we <= 0.
- Flush:
  - flush_valid forces commit_ready = 0.
  - It does NOT cancel pend_free or pend_store, because those entries are architecturally committed; both keep handshaking to completion.
  - Counters are unaffected by flush.
- Counter width: counters wrap modulo 2^CNT_W_P.
- Commit filtering:
  - rd_arch == 0 never frees and never writes the ARAT, even when uses_rd = 1.
  - Entries with no side effects still increment the counters.

Test Plan:
1. Reset, then commit {uses_rd=1, rd_arch=3, pd_new=40, pd_old=7}, free_ready=1 -> next cycle arat_we=1, arat_rd=3, arat_pd=40, free_valid=1, free_pd=7, retired_cnt=1.
2. Four back-to-back ALU commits with free_ready=1 -> commit_ready high every cycle; free_pd sequence matches the pd_old values in order; retired_cnt=4.
3. Store commit at rob_idx=5 with st_commit_ready=0 for 3 cycles -> st_commit_valid and st_commit_rob_idx=5 held stable, commit_ready=0 during the stall; on the ready cycle the next entry is accepted in the same cycle.
4. Commit with rd_arch=0, uses_rd=1 -> no arat_we, no free_valid; retired_cnt still increments.
5. Branch commits {is_branch=1, mispredict=1} then {is_branch=1, mispredict=0} -> branch_cnt=2, mispredict_cnt=1.
6. Pending free (free_ready=0) when flush_valid pulses, then assert rst one cycle after flush -> the flush cycle leaves free_valid held with payload unchanged and commit_ready=0; after rst all outputs and counters are 0.

Source files
------------

// File: rtl/commit_unit.sv
// Retire-stage consumer of the ROB commit handshake: updates the architectural RAT,
// returns old physical registers to the free list, releases stores and counts retirements.

package commit_unit_pkg;
  localparam int ROB_W  = 6;
  localparam int PHYS_W = 7;
  localparam int ARCH_W = 5;
  localparam int PC_W   = 32;

  typedef struct packed {
    logic              uses_rd;
    logic [ARCH_W-1:0] rd_arch;
    logic [PHYS_W-1:0] pd_new;
    logic [PHYS_W-1:0] pd_old;
    logic              is_branch;
    logic              mispredict;
    logic              is_store;
    logic [PC_W-1:0]   pc;
  } rob_entry_t;
endpackage

module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ROB_W_P  = commit_unit_pkg::ROB_W,
  parameter int PHYS_W_P = commit_unit_pkg::PHYS_W,
  parameter int ARCH_W_P = commit_unit_pkg::ARCH_W,
  parameter int CNT_W_P  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                commit_valid,
  output logic                commit_ready,
  input  rob_entry_t          commit_entry,
  input  logic [ROB_W_P-1:0]  commit_rob_idx,
  input  logic                flush_valid,
  output logic                arat_we,
  output logic [ARCH_W_P-1:0] arat_rd,
  output logic [PHYS_W_P-1:0] arat_pd,
  output logic                free_valid,
  input  logic                free_ready,
  output logic [PHYS_W_P-1:0] free_pd,
  output logic                st_commit_valid,
  input  logic                st_commit_ready,
  output logic [ROB_W_P-1:0]  st_commit_rob_idx,
  output logic [CNT_W_P-1:0]  retired_cnt,
  output logic [CNT_W_P-1:0]  branch_cnt,
  output logic [CNT_W_P-1:0]  mispredict_cnt
);

  logic pend_free;
  logic pend_store;
  logic free_fire;
  logic st_fire;
  logic commit_fire;
  logic writes_rd;
  logic unused_pc;

  assign unused_pc = ^commit_entry.pc;

  assign free_valid      = pend_free;
  assign st_commit_valid = pend_store;
  assign free_fire       = free_valid && free_ready;
  assign st_fire         = st_commit_valid && st_commit_ready;

  // A slot may be reused in the same cycle its previous request fires, giving 1 entry/cycle.
  assign commit_ready = !flush_valid && (!pend_free || free_fire) && (!pend_store || st_fire);
  assign commit_fire  = commit_valid && commit_ready;

  // x0 is hardwired: never remap it and never free its old mapping.
  assign writes_rd = commit_entry.uses_rd && (commit_entry.rd_arch != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      arat_we           <= 1'b0;
      arat_rd           <= '0;
      arat_pd           <= '0;
      pend_free         <= 1'b0;
      free_pd           <= '0;
      pend_store        <= 1'b0;
      st_commit_rob_idx <= '0;
      retired_cnt       <= '0;
      branch_cnt        <= '0;
      mispredict_cnt    <= '0;
    end else begin
      arat_we <= 1'b0;
      if (commit_fire) begin
        arat_we           <= writes_rd;
        arat_rd           <= commit_entry.rd_arch;
        arat_pd           <= commit_entry.pd_new;
        pend_free         <= writes_rd;
        free_pd           <= commit_entry.pd_old;
        pend_store        <= commit_entry.is_store;
        st_commit_rob_idx <= commit_rob_idx;
        retired_cnt       <= retired_cnt + 1'b1;
        branch_cnt        <= branch_cnt + CNT_W_P'(commit_entry.is_branch);
        mispredict_cnt    <= mispredict_cnt
                             + CNT_W_P'(commit_entry.is_branch && commit_entry.mispredict);
      end else begin
        // Flush never cancels these: the entries are already architecturally committed.
        if (free_fire) pend_free  <= 1'b0;
        if (st_fire)   pend_store <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: a cycle model predicts acceptance and counters,
// queues hold expected ARAT writes, frees and store releases for a negedge monitor.

module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam int CNT_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               commit_valid = 1'b0;
  logic               commit_ready;
  rob_entry_t         commit_entry = '0;
  logic [ROB_W-1:0]   commit_rob_idx = '0;
  logic               flush_valid = 1'b0;
  logic               arat_we;
  logic [ARCH_W-1:0]  arat_rd;
  logic [PHYS_W-1:0]  arat_pd;
  logic               free_valid;
  logic               free_ready = 1'b0;
  logic [PHYS_W-1:0]  free_pd;
  logic               st_commit_valid;
  logic               st_commit_ready = 1'b0;
  logic [ROB_W-1:0]   st_commit_rob_idx;
  logic [CNT_W-1:0]   retired_cnt;
  logic [CNT_W-1:0]   branch_cnt;
  logic [CNT_W-1:0]   mispredict_cnt;

  commit_unit #(.CNT_W_P(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_entry(commit_entry), .commit_rob_idx(commit_rob_idx),
    .flush_valid(flush_valid),
    .arat_we(arat_we), .arat_rd(arat_rd), .arat_pd(arat_pd),
    .free_valid(free_valid), .free_ready(free_ready), .free_pd(free_pd),
    .st_commit_valid(st_commit_valid), .st_commit_ready(st_commit_ready),
    .st_commit_rob_idx(st_commit_rob_idx),
    .retired_cnt(retired_cnt), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                due;
    logic [ARCH_W-1:0] rd;
    logic [PHYS_W-1:0] pd;
  } arat_exp_t;

  arat_exp_t         arat_q[$];
  logic [PHYS_W-1:0] free_q[$];
  logic [ROB_W-1:0]  st_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit in_reset = 1'b1;

  // Architectural model state: outstanding request flags and counters.
  bit             m_pend_free;
  bit             m_pend_store;
  logic [CNT_W-1:0] m_retired;
  logic [CNT_W-1:0] m_branch;
  logic [CNT_W-1:0] m_mispred;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: consumes expected responses whenever the DUT presents them.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (arat_we) begin
        if (arat_q.size() == 0) begin
          check("arat_spurious", 1, 0);
        end else begin
          arat_exp_t e;
          e = arat_q.pop_front();
          check("arat_rd", arat_rd, e.rd);
          check("arat_pd", arat_pd, e.pd);
          check("arat_latency", cyc, e.due);
        end
      end else if (arat_q.size() > 0 && arat_q[0].due <= cyc) begin
        check("arat_missing", 0, 1);
        void'(arat_q.pop_front());
      end
      if (free_valid) begin
        if (free_q.size() == 0) check("free_spurious", 1, 0);
        else begin
          check("free_pd", free_pd, free_q[0]);
          if (free_ready) void'(free_q.pop_front());
        end
      end
      if (st_commit_valid) begin
        if (st_q.size() == 0) check("st_spurious", 1, 0);
        else begin
          check("st_rob_idx", st_commit_rob_idx, st_q[0]);
          if (st_commit_ready) void'(st_q.pop_front());
        end
      end
    end
  end

  function automatic rob_entry_t mk(input logic u, input logic [ARCH_W-1:0] rd,
                                    input logic [PHYS_W-1:0] pn, input logic [PHYS_W-1:0] po,
                                    input logic br, input logic mp, input logic st);
    rob_entry_t e;
    e.uses_rd = u; e.rd_arch = rd; e.pd_new = pn; e.pd_old = po;
    e.is_branch = br; e.mispredict = mp; e.is_store = st;
    e.pc = $urandom;
    return e;
  endfunction

  // One cycle of stimulus; checks live outputs against the model, then advances the model.
  task automatic step(input logic v, input rob_entry_t e, input logic [ROB_W-1:0] idx,
                      input logic fr, input logic sr, input logic fl);
    bit exp_ready, wr;
    arat_exp_t a;
    @(posedge clk); #1;
    commit_valid = v; commit_entry = e; commit_rob_idx = idx;
    free_ready = fr; st_commit_ready = sr; flush_valid = fl;
    #1;
    check("free_valid", free_valid, m_pend_free);
    check("st_commit_valid", st_commit_valid, m_pend_store);
    check("retired_cnt", retired_cnt, m_retired);
    check("branch_cnt", branch_cnt, m_branch);
    check("mispredict_cnt", mispredict_cnt, m_mispred);
    exp_ready = !fl && (!m_pend_free || fr) && (!m_pend_store || sr);
    check("commit_ready", commit_ready, exp_ready);
    if (m_pend_free && fr)  m_pend_free  = 1'b0;
    if (m_pend_store && sr) m_pend_store = 1'b0;
    if (v && exp_ready) begin
      wr = e.uses_rd && (e.rd_arch != 0);
      m_retired = m_retired + 1;
      if (e.is_branch) m_branch = m_branch + 1;
      if (e.is_branch && e.mispredict) m_mispred = m_mispred + 1;
      if (wr) begin
        a.due = cyc + 1; a.rd = e.rd_arch; a.pd = e.pd_new;
        arat_q.push_back(a);
        free_q.push_back(e.pd_old);
        m_pend_free = 1'b1;
      end
      if (e.is_store) begin
        st_q.push_back(idx);
        m_pend_store = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic fr, input logic sr);
    step(1'b0, '0, '0, fr, sr, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_reset = 1'b1;
    rst = 1'b1;
    commit_valid = 1'b0; flush_valid = 1'b0; free_ready = 1'b0; st_commit_ready = 1'b0;
    m_pend_free = 0; m_pend_store = 0; m_retired = '0; m_branch = '0; m_mispred = '0;
    arat_q.delete(); free_q.delete(); st_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_arat_we", arat_we, 0);
    check("rst_arat_rd", arat_rd, 0);
    check("rst_arat_pd", arat_pd, 0);
    check("rst_free_valid", free_valid, 0);
    check("rst_free_pd", free_pd, 0);
    check("rst_st_valid", st_commit_valid, 0);
    check("rst_st_idx", st_commit_rob_idx, 0);
    check("rst_retired", retired_cnt, 0);
    check("rst_branch", branch_cnt, 0);
    check("rst_mispred", mispredict_cnt, 0);
    in_reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Basic ALU commit.
    step(1, mk(1, 5'd3, 7'd40, 7'd7, 0, 0, 0), 6'd1, 1, 1, 0);
    idle(1, 1);
    check("t1_arat_we", arat_we, 1);
    check("t1_arat_rd", arat_rd, 3);
    check("t1_arat_pd", arat_pd, 40);
    check("t1_free_valid", free_valid, 1);
    check("t1_free_pd", free_pd, 7);
    check("t1_retired", retired_cnt, 1);

    // Four back-to-back ALU commits.
    for (int i = 0; i < 4; i++)
      step(1, mk(1, 5'(i + 1), 7'(50 + i), 7'(10 + i), 0, 0, 0), 6'(i), 1, 1, 0);
    idle(1, 1);
    check("t2_retired", retired_cnt, 5);

    // Store stalled for three cycles, then released while the next entry enters.
    step(1, mk(0, 5'd0, 7'd0, 7'd0, 0, 0, 1), 6'd5, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, mk(1, 5'd8, 7'd60, 7'd61, 0, 0, 0), 6'd6, 1, 0, 0);
    check("t3_st_idx_held", st_commit_rob_idx, 5);
    check("t3_stalled", commit_ready, 0);
    step(1, mk(1, 5'd8, 7'd60, 7'd61, 0, 0, 0), 6'd6, 1, 1, 0);
    idle(1, 1);

    // rd_arch == 0 retires without side effects.
    step(1, mk(1, 5'd0, 7'd70, 7'd71, 0, 0, 0), 6'd7, 1, 1, 0);
    idle(1, 1);
    check("t4_no_arat", arat_we, 0);
    check("t4_no_free", free_valid, 0);

    // Branch statistics.
    step(1, mk(0, 5'd0, 7'd0, 7'd0, 1, 1, 0), 6'd8, 1, 1, 0);
    step(1, mk(0, 5'd0, 7'd0, 7'd0, 1, 0, 0), 6'd9, 1, 1, 0);
    idle(1, 1);
    check("t5_branch", branch_cnt, 2);
    check("t5_mispred", mispredict_cnt, 1);

    // Flush while a free is pending, then reset.
    step(1, mk(1, 5'd9, 7'd80, 7'd21, 0, 0, 0), 6'd10, 0, 1, 0);
    idle(0, 1);
    step(1, mk(1, 5'd4, 7'd90, 7'd91, 0, 0, 0), 6'd11, 0, 1, 1);
    check("t6_flush_free_pd", free_pd, 21);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rob_entry_t e;
      logic [ARCH_W-1:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? '0 : ARCH_W'($urandom);
      e = mk(1'($urandom), rd, PHYS_W'($urandom), PHYS_W'($urandom),
             1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      step($urandom_range(0, 3) != 0, e, ROB_W'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0);
    end

    for (int i = 0; i < 4; i++) idle(1, 1);
    check("drain_arat_q", arat_q.size(), 0);
    check("drain_free_q", free_q.size(), 0);
    check("drain_st_q", st_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
